// File: rtl/common_pkg.sv
// Shared bus-master definitions: Wishbone widths, the RAM window base, a time-to-cycles
// helper and the one-hot state type reused by every bus master in the design.
package common_pkg;

  localparam int WB_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH    = 8;

  localparam logic [WB_ADDR_WIDTH-1:0] WB_RAM_BASE = 16'h4000;

  typedef enum logic [2:0] {
    WB_IDLE = 3'b001,
    WB_REQ  = 3'b010,
    WB_WAIT = 3'b100
  } wb_master_state_t;

  // Rounds up so a delay is never shorter than requested.
  function automatic int ns_to_cycles(input int ns, input int clk_mhz);
    return (ns * clk_mhz + 999) / 1000;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone B4 pipelined master: one command becomes one bus cycle, with
// stall/ack handling, read-data return and a timeout against a slave that never acks.
module wb_cmd_master
  import common_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  output logic [2:0]               dbg_state_o
);

  // Handshake: a command transfers on a clock edge where cmd_valid_i and cmd_ready_o are
  // both 1; rsp_valid_o is a one-cycle pulse with no back-pressure.
  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  wb_master_state_t r_state, w_state;

  logic                     r_cmd_ready, w_cmd_ready;
  logic                     r_rsp_valid, w_rsp_valid;
  logic                     r_rsp_err, w_rsp_err;
  logic [DATA_WIDTH-1:0]    r_rsp_data, w_rsp_data;
  logic [WB_ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0]    r_data, w_data;
  logic                     r_we, w_we;
  logic                     r_cyc, w_cyc;
  logic                     r_stb, w_stb;
  logic [7:0]               r_cnt, w_cnt;
  logic [7:0]               w_cnt_inc;
  logic                     w_done_ok;
  logic                     w_done_err;

  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      r_state     <= WB_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_data  <= w_rsp_data;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_we        <= w_we;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_data  = r_rsp_data;
    w_addr      = r_addr;
    w_data      = r_data;
    w_we        = r_we;
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_cnt       = r_cnt;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;

    unique case (r_state)
      WB_IDLE: begin
        w_cmd_ready = 1'b1;
        if (r_cmd_ready && cmd_valid_i) begin
          w_cmd_ready = 1'b0;
          w_addr      = cmd_addr_i;
          w_data      = cmd_data_i;
          w_we        = cmd_we_i;
          w_cyc       = 1'b1;
          w_stb       = 1'b1;
          w_cnt       = '0;
          w_state     = WB_REQ;
        end
      end
      WB_REQ: begin
        // An ack only counts once the request itself has been accepted (stall low).
        if (!wb_stall_i && wb_ack_i) begin
          w_done_ok = 1'b1;
        end else if (r_cnt == LP_LAST_CNT) begin
          w_done_err = 1'b1;
        end else begin
          w_cnt = w_cnt_inc;
          if (!wb_stall_i) begin
            w_stb   = 1'b0;
            w_state = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (wb_ack_i) begin
          w_done_ok = 1'b1;
        end else if (r_cnt == LP_LAST_CNT) begin
          w_done_err = 1'b1;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: w_state = WB_IDLE;
    endcase

    if (w_done_ok || w_done_err) begin
      w_cyc       = 1'b0;
      w_stb       = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_err   = w_done_err;
      w_cmd_ready = 1'b1;
      w_state     = WB_IDLE;
    end
    if (w_done_ok && !r_we) begin
      w_rsp_data = wb_data_i;
    end
    if (w_done_err) begin
      w_rsp_data = '0;
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_data_o  = r_rsp_data;
  assign wb_addr_o   = r_addr;
  assign wb_data_o   = r_data;
  assign wb_we_o     = r_we;
  assign wb_cycle_o  = r_cyc;
  assign wb_strobe_o = r_stb;
  assign dbg_state_o = r_state;

endmodule
